// File: rtl/audio_path_sched.sv
// ---------------------------------------------------------------------------
// audio_path_sched
// Sequences each audio sample from the receive side (comunication) through an
// optional effect stage to dac_driver. It holds one sample in flight and one
// pending sample. It counts samples dropped when both are occupied.
//
// Build option:
//   AUDIO_SCHED_WDOG_EN  When defined, an effect-stage watchdog is built. A
//                        stalled effect falls back to the raw sample and sets
//                        the sticky wdog_flag.
//
// Ports:
//   clk_25mhz   in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   in_valid    in   1-cycle pulse: in_sample valid
//   in_sample   in   [15:0] input audio sample
//   bypass_en   in   1 = route the sample around the effect
//   eff_start   out  1-cycle pulse: eff_sample valid, start processing
//   eff_sample  out  [15:0] sample sent to the effect
//   eff_done    in   1-cycle pulse: eff_result valid
//   eff_result  in   [15:0] processed sample
//   dac_valid   out  dac_sample valid
//   dac_sample  out  [15:0] sample sent to dac_driver
//   dac_ready   in   dac_driver accepts the sample this cycle
//   busy        out  path not idle, or pending slot occupied
//   overrun     out  sticky: at least one sample dropped
//   drop_count  out  [CNT_W-1:0] saturating dropped-sample count
//   clr_status  in   1-cycle pulse: clear overrun/drop_count/wdog_flag
//   wdog_flag   out  sticky: effect timed out (0 when watchdog not built)
// ---------------------------------------------------------------------------
module audio_path_sched #(
  parameter int unsigned CNT_W = 8
`ifdef AUDIO_SCHED_WDOG_EN
  ,
  parameter int unsigned clock_max = 25_000_000,
  parameter int unsigned audio_clk = 400
`endif
) (
  input  logic             clk_25mhz,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [15:0]      in_sample,
  input  logic             bypass_en,
  output logic             eff_start,
  output logic [15:0]      eff_sample,
  input  logic             eff_done,
  input  logic [15:0]      eff_result,
  output logic             dac_valid,
  output logic [15:0]      dac_sample,
  input  logic             dac_ready,
  output logic             busy,
  output logic             overrun,
  output logic [CNT_W-1:0] drop_count,
  input  logic             clr_status,
  output logic             wdog_flag
);

  localparam int unsigned SAMPLE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EFF_START = 2'd1,
    ST_EFF_WAIT  = 2'd2,
    ST_DAC_PUSH  = 2'd3
  } state_t;

  state_t              r_state;
  logic [SAMPLE_W-1:0] r_hold;
  logic [SAMPLE_W-1:0] r_pend;
  logic                r_pend_full;
  logic                r_eff_start;
  logic                r_dac_valid;
  logic [SAMPLE_W-1:0] r_dac_sample;
  logic                r_overrun;
  logic [CNT_W-1:0]    r_drop_count;

  logic                w_idle;
  logic                w_src_valid;
  logic [SAMPLE_W-1:0] w_src_sample;
  logic                w_drop;
  logic                w_timeout;

  // In IDLE the pending slot has priority over a fresh input.
  assign w_idle       = (r_state == ST_IDLE);
  assign w_src_valid  = r_pend_full | in_valid;
  assign w_src_sample = r_pend_full ? r_pend : in_sample;

  // A sample arriving while busy with the slot already occupied is lost.
  assign w_drop = !w_idle && in_valid && r_pend_full;

`ifdef AUDIO_SCHED_WDOG_EN
  localparam int unsigned WDOG_CYCLES = clock_max / audio_clk;
  localparam int unsigned WDOG_W      = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_wdog_flag;

  // eff_done arriving on the final count still wins over the timeout.
  assign w_timeout = (r_state == ST_EFF_WAIT) && !eff_done &&
                     (r_wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

  // Watchdog counter: restarts from 0 on every entry to EFF_WAIT.
  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      r_wdog_cnt <= '0;
    end else if (r_state != ST_EFF_WAIT) begin
      r_wdog_cnt <= '0;
    end else if (r_wdog_cnt != WDOG_W'(WDOG_CYCLES - 1)) begin
      r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
    end
  end

  // Sticky timeout flag; a timeout in the same cycle as clr_status keeps it set.
  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      r_wdog_flag <= 1'b0;
    end else if (w_timeout) begin
      r_wdog_flag <= 1'b1;
    end else if (clr_status) begin
      r_wdog_flag <= 1'b0;
    end
  end

  assign wdog_flag = r_wdog_flag;
`else
  assign w_timeout = 1'b0;
  assign wdog_flag = 1'b0;
`endif

  // Path sequencer with registered handshake outputs.
  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_hold       <= '0;
      r_eff_start  <= 1'b0;
      r_dac_valid  <= 1'b0;
      r_dac_sample <= '0;
    end else begin
      r_eff_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_src_valid) begin
            r_hold <= w_src_sample;
            if (bypass_en) begin
              r_state      <= ST_DAC_PUSH;
              r_dac_valid  <= 1'b1;
              r_dac_sample <= w_src_sample;
            end else begin
              r_state     <= ST_EFF_START;
              r_eff_start <= 1'b1;
            end
          end
        end
        ST_EFF_START: begin
          r_state <= ST_EFF_WAIT;
        end
        ST_EFF_WAIT: begin
          if (eff_done) begin
            r_state      <= ST_DAC_PUSH;
            r_dac_valid  <= 1'b1;
            r_dac_sample <= eff_result;
          end else if (w_timeout) begin
            // Fall back to the unprocessed sample.
            r_state      <= ST_DAC_PUSH;
            r_dac_valid  <= 1'b1;
            r_dac_sample <= r_hold;
          end
        end
        ST_DAC_PUSH: begin
          if (dac_ready) begin
            r_state     <= ST_IDLE;
            r_dac_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_dac_valid <= 1'b0;
        end
      endcase
    end
  end

  // One-entry pending slot.
  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      r_pend      <= '0;
      r_pend_full <= 1'b0;
    end else if (w_idle) begin
      // IDLE consumes the slot; a simultaneous input refills it.
      if (r_pend_full && in_valid) begin
        r_pend <= in_sample;
      end else if (r_pend_full) begin
        r_pend_full <= 1'b0;
      end
    end else if (in_valid && !r_pend_full) begin
      r_pend      <= in_sample;
      r_pend_full <= 1'b1;
    end
  end

  // Drop accounting; a drop coinciding with clr_status restarts the count at 1.
  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      r_overrun    <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
      if (clr_status) begin
        r_drop_count <= CNT_W'(1);
      end else if (r_drop_count != {CNT_W{1'b1}}) begin
        r_drop_count <= r_drop_count + CNT_W'(1);
      end
    end else if (clr_status) begin
      r_overrun    <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign eff_start  = r_eff_start;
  assign eff_sample = r_hold;
  assign dac_valid  = r_dac_valid;
  assign dac_sample = r_dac_sample;
  assign busy       = (r_state != ST_IDLE) || r_pend_full;
  assign overrun    = r_overrun;
  assign drop_count = r_drop_count;

endmodule
